shift_rotate_pipe: RTL and testbench

Pipelined, parametrised shift/rotate unit for the datapath ALU: generalises the fixed 32-bit combinational rotate-left to any power-of-two width. It supports five modes (ROL, ROR, SHL, SHR, SRA) with defined behaviour for over-range shift amounts. It has one register stage per shift bit and a valid/ready handshake on both sides, so it can sit between the operand latch and the result bus without lengthening the ALU critical path.

---
 rtl/shift_pkg.sv | 24 ++
 rtl/shift_rotate_pipe_stage.sv | 61 ++++++
 rtl/shift_rotate_pipe.sv | 131 +++++++++++++
 tb/tb_shift_rotate_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the pipelined shift/rotate unit.
// Op codes, per-stage control bundle and op classification.
package shift_pkg;

    // Codes 5..7 are reserved: the operand passes through unchanged.
    typedef enum logic [2:0] {
        OP_ROL = 3'd0,
        OP_ROR = 3'd1,
        OP_SHL = 3'd2,
        OP_SHR = 3'd3,
        OP_SRA = 3'd4
    } shift_op_t;

    // Control that rides alongside the data through every stage.
    typedef struct packed {
        shift_op_t op;
        logic      sat;
    } shift_ctl_t;

    function automatic logic is_shift(input shift_op_t op);
        return op inside {OP_SHL, OP_SHR, OP_SRA};
    endfunction

endpackage

// File: rtl/shift_rotate_pipe_stage.sv
// One register stage: moves the data by 2^K positions when amt_bit is set,
// with a valid bit and a combinational upstream ready.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int K     = 0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic             down_ready,
    input  logic             amt_bit,
    input  logic [WIDTH-1:0] in_data,
    input  shift_ctl_t       in_ctl,
    input  logic [TAG_W-1:0] in_tag,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output shift_ctl_t       ctl,
    output logic [TAG_W-1:0] tag
);

    localparam int S = 1 << K;

    logic [WIDTH-1:0] moved;

    always_comb begin
        moved = in_data;
        if (amt_bit) begin
            unique case (in_ctl.op)
                OP_ROL:  moved = (in_data << S) | (in_data >> (WIDTH - S));
                OP_ROR:  moved = (in_data >> S) | (in_data << (WIDTH - S));
                OP_SHL:  moved = in_data << S;
                OP_SHR:  moved = in_data >> S;
                OP_SRA:  moved = $unsigned($signed(in_data) >>> S);
                default: moved = in_data;
            endcase
        end
    end

    assign up_ready = !valid || down_ready;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            valid <= 1'b0;
            data  <= '0;
            ctl   <= '0;
            tag   <= '0;
        end else if (up_ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= moved;
                ctl  <= in_ctl;
                tag  <= in_tag;
            end
        end
    end

endmodule

// File: rtl/shift_rotate_pipe.sv
// Pipelined ROL/ROR/SHL/SHR/SRA unit, one stage per amount bit,
// valid/ready on both sides, saturation for amounts >= WIDTH.
module shift_rotate_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int NSTAGE = $clog2(WIDTH),
    localparam int AMT_W  = NSTAGE + 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    shift_ctl_t entry_ctl;

    // Rotates wrap, so only shifts saturate on the top amount bit.
    always_comb begin
        entry_ctl.op  = shift_op_t'(in_op);
        entry_ctl.sat = in_amt[NSTAGE] && is_shift(entry_ctl.op);
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : stg
        logic             valid;
        logic             up_ready;
        logic             down_ready;
        logic             src_valid;
        logic             amt_bit;
        logic [WIDTH-1:0] src_data;
        logic [WIDTH-1:0] data;
        shift_ctl_t       src_ctl;
        shift_ctl_t       ctl;
        logic [TAG_W-1:0] src_tag;
        logic [TAG_W-1:0] tag;

        if (k == 0) begin : g_src
            assign src_valid = in_valid;
            assign src_data  = in_data;
            assign src_ctl   = entry_ctl;
            assign src_tag   = in_tag;
            assign amt_bit   = in_amt[0];
        end else begin : g_src
            assign src_valid = stg[k-1].valid;
            assign src_data  = stg[k-1].data;
            assign src_ctl   = stg[k-1].ctl;
            assign src_tag   = stg[k-1].tag;
            assign amt_bit   = stg[k-1].g_amt.amt[k];
        end

        if (k == NSTAGE - 1) begin : g_dn
            assign down_ready = out_ready;
        end else begin : g_dn
            assign down_ready = stg[k+1].up_ready;
        end

        // Only the amount bits still needed downstream are carried.
        if (k < NSTAGE - 1) begin : g_amt
            logic [NSTAGE-1:k+1] amt;
            logic [NSTAGE-1:k+1] src_amt;

            if (k == 0) begin : g_first
                assign src_amt = in_amt[NSTAGE-1:1];
            end else begin : g_first
                assign src_amt = stg[k-1].g_amt.amt[NSTAGE-1:k+1];
            end

            always_ff @(posedge clock or posedge clear) begin
                if (clear) begin
                    amt <= '0;
                end else if (up_ready && src_valid) begin
                    amt <= src_amt;
                end
            end
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .K     (k)
        ) u_stage (
            .clock      (clock),
            .clear      (clear),
            .up_valid   (src_valid),
            .up_ready   (up_ready),
            .down_ready (down_ready),
            .amt_bit    (amt_bit),
            .in_data    (src_data),
            .in_ctl     (src_ctl),
            .in_tag     (src_tag),
            .valid      (valid),
            .data       (data),
            .ctl        (ctl),
            .tag        (tag)
        );
    end

    logic [WIDTH-1:0] last_data;
    shift_ctl_t       last_ctl;

    assign last_data = stg[NSTAGE-1].data;
    assign last_ctl  = stg[NSTAGE-1].ctl;

    // SRA keeps its sign in the MSB through every stage, so it fills from there.
    always_comb begin
        out_data = last_data;
        if (last_ctl.sat) begin
            if (last_ctl.op == OP_SRA) begin
                out_data = {WIDTH{last_data[WIDTH-1]}};
            end else begin
                out_data = '0;
            end
        end
    end

    assign in_ready  = stg[0].up_ready;
    assign out_valid = stg[NSTAGE-1].valid;
    assign out_tag   = stg[NSTAGE-1].tag;
    assign out_zero  = out_valid && (out_data == '0);

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Bench for shift_rotate_pipe at WIDTH 32: vector table, back-pressure,
// random stream against a reference model, and mid-operation reset.
module tb_shift_rotate_pipe;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [W-1:0]  in_data;
    logic [AW-1:0] in_amt;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_zero;
    logic [TW-1:0] out_tag;

    shift_rotate_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clock     (clk),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [5:0]  amt;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [3:0] tag;
        int         cyc;
    } log_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_in  = 0;
    int   n_out = 0;
    exp_t exp_q[$];
    log_t out_log[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Reference: rotations via a doubled word, shifts via native operators.
    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] d,
                                          input logic [5:0] amt);
        logic [63:0] dd;
        int          r;
        r  = int'(amt) % 32;
        dd = {d, d};
        if (amt == 0) return d;
        case (op)
            3'd0: begin dd = dd << r; return dd[63:32]; end
            3'd1: begin dd = dd >> r; return dd[31:0]; end
            3'd2: return (amt >= 32) ? 32'h0 : d << amt;
            3'd3: return (amt >= 32) ? 32'h0 : d >> amt;
            3'd4: return (amt >= 32) ? {32{d[31]}} : 32'($signed(d) >>> amt);
            default: return d;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expected results queued at input transfer, popped at output.
    always @(negedge clk) begin
        if (clear) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                out_log.push_back('{tag: out_tag, cyc: cyc});
                if (exp_q.size() == 0) begin
                    check("sb_extra_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_data", out_data, e.data);
                    check("sb_tag", 32'(out_tag), 32'(e.tag));
                    check("sb_zero", 32'(out_zero), 32'(e.data == 0));
                end
            end
            if (in_valid && in_ready) begin
                n_in++;
                exp_q.push_back('{data: model(in_op, in_data, in_amt), tag: in_tag});
            end
        end
    end

    task automatic run_one(input logic [2:0] op, input logic [31:0] d,
                           input logic [5:0] a, input logic [3:0] t,
                           output logic [31:0] rd, output logic rz,
                           output int lat);
        in_op    = op;
        in_data  = d;
        in_amt   = a;
        in_tag   = t;
        in_valid = 1'b1;
        @(negedge clk);
        check("issue_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = out_data;
        rz = out_zero;
    endtask

    task automatic rand_inputs();
        in_op   = 3'($urandom_range(0, 7));
        in_data = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        in_amt  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                              : 6'($urandom_range(0, 31));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        rz;
        int          lat;
        int          guard;
        int          i;
        logic        acc;
        logic [31:0] bp_d1;

        clear     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_data   = '0;
        in_amt    = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        #1 clear = 1'b1;
        #10;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 clear = 1'b0;

        vecs.push_back('{op: 3'd0, data: 32'h80000001, amt: 6'd1,  exp: 32'h00000003});
        vecs.push_back('{op: 3'd0, data: 32'h80000001, amt: 6'd33, exp: 32'h00000003});
        vecs.push_back('{op: 3'd1, data: 32'h00000001, amt: 6'd4,  exp: 32'h10000000});
        vecs.push_back('{op: 3'd3, data: 32'hF0000000, amt: 6'd4,  exp: 32'h0F000000});
        vecs.push_back('{op: 3'd2, data: 32'h00000001, amt: 6'd31, exp: 32'h80000000});
        vecs.push_back('{op: 3'd4, data: 32'h80000000, amt: 6'd40, exp: 32'hFFFFFFFF});
        vecs.push_back('{op: 3'd2, data: 32'h12345678, amt: 6'd32, exp: 32'h00000000});
        vecs.push_back('{op: 3'd4, data: 32'h7FFFFFFF, amt: 6'd63, exp: 32'h00000000});
        vecs.push_back('{op: 3'd1, data: 32'h00000001, amt: 6'd63, exp: 32'h00000002});
        vecs.push_back('{op: 3'd4, data: 32'h80000000, amt: 6'd4,  exp: 32'hF8000000});
        vecs.push_back('{op: 3'd3, data: 32'h80000000, amt: 6'd40, exp: 32'h00000000});
        vecs.push_back('{op: 3'd5, data: 32'hDEADBEEF, amt: 6'd7,  exp: 32'hDEADBEEF});
        for (int o = 0; o < 8; o++) begin
            vecs.push_back('{op: 3'(o), data: 32'hDEADBEEF, amt: 6'd0, exp: 32'hDEADBEEF});
        end

        foreach (vecs[v]) begin
            run_one(vecs[v].op, vecs[v].data, vecs[v].amt, 4'(v), rd, rz, lat);
            check($sformatf("vec%0d_data", v), rd, vecs[v].exp);
            check($sformatf("vec%0d_zero", v), 32'(rz), 32'(vecs[v].exp == 0));
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'd5);
        end
        repeat (3) @(posedge clk);
        #1;

        // Back-pressure: five fill the pipe, the sixth waits for out_ready.
        out_ready = 1'b0;
        out_log.delete();
        for (int t = 1; t <= 5; t++) begin
            rand_inputs();
            in_tag   = 4'(t);
            in_valid = 1'b1;
            if (t == 1) bp_d1 = model(in_op, in_data, in_amt);
            @(negedge clk);
            check($sformatf("bp_accept%0d", t), 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        rand_inputs();
        in_tag = 4'd6;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_full_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_tag", 32'(out_tag), 32'd1);
            check("bp_hold_data", out_data, bp_d1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_simul_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rand_inputs();
        in_tag = 4'd7;
        @(negedge clk);
        check("bp_accept7", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("bp_out_count", 32'(out_log.size()), 32'd7);
        for (int k = 0; k < out_log.size() && k < 7; k++) begin
            check($sformatf("bp_order%0d", k), 32'(out_log[k].tag), 32'(k + 1));
            check($sformatf("bp_nogap%0d", k), 32'(out_log[k].cyc - out_log[0].cyc),
                  32'(k));
        end

        // Random stream with random back-pressure.
        n_in  = 0;
        n_out = 0;
        i     = 0;
        guard = 0;
        rand_inputs();
        in_tag   = 4'($urandom_range(0, 15));
        in_valid = 1'b1;
        while (i < 100 && guard < 3000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
            out_ready = 1'($urandom_range(0, 1));
            if (acc) begin
                i++;
                if (i < 100) begin
                    rand_inputs();
                    in_tag = 4'($urandom_range(0, 15));
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check("stream_issued", 32'(i), 32'd100);
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        check("stream_in_count", 32'(n_in), 32'd100);
        check("stream_out_count", 32'(n_out), 32'd100);

        // Reset with three operations in flight.
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            rand_inputs();
            in_tag   = 4'(t + 8);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #3 clear = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_out_data", out_data, 32'd0);
        check("rst_mid_out_tag", 32'(out_tag), 32'd0);
        @(posedge clk);
        #3 clear = 1'b0;
        out_ready = 1'b1;
        out_log.delete();
        @(posedge clk);
        #1;
        run_one(3'd1, 32'h00000001, 6'd1, 4'd3, rd, rz, lat);
        check("post_rst_data", rd, 32'h80000000);
        check("post_rst_latency", 32'(lat), 32'd5);
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_no_stale", 32'(out_log.size()), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
